// File: rtl/cpu_pkg.sv
// Shared pipeline-control definitions: hazard FSM encodings, the zero register
// and the all-zero control bundle that a bubble loads into DX.
package cpu_pkg;

   localparam int REG_W = 5;
   localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

   typedef enum logic [1:0] {
      HZ_INIT  = 2'd0,
      HZ_RUN   = 2'd1,
      HZ_STALL = 2'd2,
      HZ_FLUSH = 2'd3
   } hz_state_t;

   typedef struct packed {
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic       jump;
      logic       alusrc;
      logic [3:0] aluop;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters with one load port and two busy read ports.
// A counter at 1 means the write lands this cycle and is visible through the register file.
module hazard_scoreboard
   import cpu_pkg::*;
#(
   parameter int WB_LAT = 3,
   parameter int NREG   = 32
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [REG_W-1:0] i_load_reg,
   input  logic [REG_W-1:0] i_rd_a,
   input  logic [REG_W-1:0] i_rd_b,
   output logic             o_busy_a,
   output logic             o_busy_b
);

   localparam int SB_W = $clog2(WB_LAT + 1);

   logic [SB_W-1:0] r_sb [NREG];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) r_sb[i] <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) begin
            if (i_load && (i_load_reg != REG_ZERO) && (i_load_reg == REG_W'(i)))
               r_sb[i] <= SB_W'(WB_LAT);
            else if (r_sb[i] != '0)
               r_sb[i] <= r_sb[i] - SB_W'(1);
         end
      end
   end

   assign o_busy_a = (r_sb[i_rd_a] > SB_W'(1));
   assign o_busy_b = (r_sb[i_rd_b] > SB_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Interlock/flush controller for the 5-stage pipeline (no forwarding).
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush event counters.
module hazard_ctrl
   import cpu_pkg::*;
#(
   parameter int WB_LAT   = 3,
   parameter int INIT_CYC = 2,
   parameter int NREG     = 32
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs,
   input  logic [4:0] id_rt,
   input  logic       id_use_rs,
   input  logic       id_use_rt,
   input  logic [4:0] id_rd,
   input  logic       id_regwrite,
   input  logic       dx_jump,
   input  logic       xm_branch,
   output logic       stall_fd,
   output logic       bubble_dx,
   output logic       flush_fd,
   output logic       flush_dx,
   output logic       flush_xm,
   output logic [1:0] state
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] perf_stall,
   output logic [31:0] perf_flush
`endif
);

   localparam int INIT_W = (INIT_CYC > 1) ? $clog2(INIT_CYC) : 1;

   hz_state_t         r_state;
   hz_state_t         w_next;
   logic [INIT_W-1:0] r_init_cnt;

   logic w_busy_rs, w_busy_rt, w_hazard, w_issue, w_haz_stall;
   logic w_stall, w_bubble, w_fl_fd, w_fl_dx, w_fl_xm;

   hazard_scoreboard #(
      .WB_LAT (WB_LAT),
      .NREG   (NREG)
   ) u_sb (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_issue),
      .i_load_reg (id_rd),
      .i_rd_a     (id_rs),
      .i_rd_b     (id_rt),
      .o_busy_a   (w_busy_rs),
      .o_busy_b   (w_busy_rt)
   );

   assign w_hazard = (id_use_rs && (id_rs != REG_ZERO) && w_busy_rs) ||
                     (id_use_rt && (id_rt != REG_ZERO) && w_busy_rt);

   // Branch in XM is older than the jump in DX, so it wins and also clears DX/XM.
   always_comb begin
      w_stall     = 1'b0;
      w_bubble    = 1'b0;
      w_fl_fd     = 1'b0;
      w_fl_dx     = 1'b0;
      w_fl_xm     = 1'b0;
      w_haz_stall = 1'b0;
      w_next      = r_state;
      if (r_state == HZ_INIT) begin
         w_stall  = 1'b1;
         w_bubble = 1'b1;
         if (r_init_cnt == INIT_W'(INIT_CYC - 1)) w_next = HZ_RUN;
      end else if (xm_branch) begin
         w_fl_fd = 1'b1;
         w_fl_dx = 1'b1;
         w_fl_xm = 1'b1;
         w_next  = HZ_FLUSH;
      end else if (dx_jump) begin
         w_fl_fd = 1'b1;
         w_next  = HZ_FLUSH;
      end else if (w_hazard) begin
         w_stall     = 1'b1;
         w_bubble    = 1'b1;
         w_haz_stall = 1'b1;
         w_next      = HZ_STALL;
      end else begin
         w_next = HZ_RUN;
      end
   end

   assign w_issue = !w_stall && !w_bubble && !w_fl_fd && id_regwrite && (id_rd != REG_ZERO);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= HZ_INIT;
         r_init_cnt <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == HZ_INIT) r_init_cnt <= r_init_cnt + INIT_W'(1);
      end
   end

   assign stall_fd  = w_stall;
   assign bubble_dx = w_bubble;
   assign flush_fd  = w_fl_fd;
   assign flush_dx  = w_fl_dx;
   assign flush_xm  = w_fl_xm;
   assign state     = r_state;

`ifdef HAZARD_PERF_EN
   logic [31:0] r_perf_stall, r_perf_flush;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == '1) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_stall <= '0;
         r_perf_flush <= '0;
      end else begin
         if (w_haz_stall) r_perf_stall <= sat_inc(r_perf_stall);
         if (w_fl_fd)     r_perf_flush <= sat_inc(r_perf_flush);
      end
   end

   assign perf_stall = r_perf_stall;
   assign perf_flush = r_perf_flush;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl: driver queues expected outputs, monitor compares.
module tb_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_regwrite = 1'b0;
   logic       dx_jump = 1'b0, xm_branch = 1'b0;
   logic       stall_fd, bubble_dx, flush_fd, flush_dx, flush_xm;
   logic [1:0] state;
`ifdef HAZARD_PERF_EN
   logic [31:0] perf_stall, perf_flush;
`endif

   localparam logic [1:0] S_INIT = 2'd0, S_RUN = 2'd1, S_STALL = 2'd2, S_FLUSH = 2'd3;
   // expected output vector {stall_fd, bubble_dx, flush_fd, flush_dx, flush_xm}
   localparam logic [4:0] O_NONE = 5'b00000, O_STALL = 5'b11000, O_JUMP = 5'b00100,
                          O_BR   = 5'b00111;

   typedef struct {
      string      name;
      logic [6:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   hazard_ctrl #(.WB_LAT(3), .INIT_CYC(2), .NREG(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .dx_jump     (dx_jump),
      .xm_branch   (xm_branch),
      .stall_fd    (stall_fd),
      .bubble_dx   (bubble_dx),
      .flush_fd    (flush_fd),
      .flush_dx    (flush_dx),
      .flush_xm    (flush_xm),
      .state       (state)
`ifdef HAZARD_PERF_EN
      ,
      .perf_stall  (perf_stall),
      .perf_flush  (perf_flush)
`endif
   );

   always #5 clk = ~clk;

   // One clock cycle of stimulus, with the outputs it must produce during that cycle.
   task automatic step(input string nm, input logic r,
                       input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic rw,
                       input logic j, input logic b,
                       input logic [1:0] es, input logic [4:0] eo);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r;
      id_rs = rs; id_use_rs = urs;
      id_rt = rt; id_use_rt = urt;
      id_rd = rd; id_regwrite = rw;
      dx_jump = j; xm_branch = b;
      e.name = nm;
      e.exp  = {es, eo};
      q.push_back(e);
   endtask

   task automatic check_now(input string nm, input logic [6:0] exp_v);
      logic [6:0] act;
      act = {state, stall_fd, bubble_dx, flush_fd, flush_dx, flush_xm};
      n_checks++;
      if (act !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b", nm, act, exp_v);
      end
   endtask

   // Monitor: every cycle that has a queued expectation is compared mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            check_now(e.name, e.exp);
         end
      end
   end

   initial begin
      int nz;
      //   name            rst rs  urs rt  urt rd  rw  j  b   state    outputs
      step("reset_hold",   1, 0,  0, 0,  0, 0,  0, 0, 0, S_INIT,  O_STALL);
      step("init_c0",      0, 0,  0, 0,  0, 7,  1, 0, 1, S_INIT,  O_STALL);
      step("init_c1",      0, 0,  0, 0,  0, 0,  0, 0, 0, S_INIT,  O_STALL);
      step("run_after",    0, 7,  1, 0,  0, 5,  1, 0, 0, S_RUN,   O_NONE);
      step("raw_stall1",   0, 5,  1, 0,  0, 6,  1, 0, 0, S_RUN,   O_STALL);
      step("raw_stall2",   0, 5,  1, 0,  0, 6,  1, 0, 0, S_STALL, O_STALL);
      step("raw_issue",    0, 5,  1, 0,  0, 6,  1, 0, 0, S_STALL, O_NONE);
      step("r0_write",     0, 0,  1, 0,  0, 0,  1, 0, 0, S_RUN,   O_NONE);
      step("r0_read",      0, 0,  1, 0,  1, 0,  0, 0, 0, S_RUN,   O_NONE);
      step("branch",       0, 0,  0, 0,  0, 0,  0, 0, 1, S_RUN,   O_BR);
      step("after_branch", 0, 0,  0, 0,  0, 0,  0, 0, 0, S_FLUSH, O_NONE);
      step("jump",         0, 0,  0, 0,  0, 0,  0, 1, 0, S_RUN,   O_JUMP);
      step("issue_r9",     0, 0,  0, 0,  0, 9,  1, 0, 0, S_FLUSH, O_NONE);
      step("rt_stall",     0, 0,  0, 9,  1, 0,  0, 0, 0, S_RUN,   O_STALL);
      step("br_jmp_stall", 0, 0,  0, 9,  1, 0,  0, 1, 1, S_STALL, O_BR);
      step("r9_landed",    0, 0,  0, 9,  1, 0,  0, 0, 0, S_FLUSH, O_NONE);
      step("issue_r11",    0, 0,  0, 0,  0, 11, 1, 0, 0, S_RUN,   O_NONE);
      step("br_on_haz",    0, 11, 1, 0,  0, 0,  0, 0, 1, S_RUN,   O_BR);
      step("restall",      0, 11, 1, 0,  0, 0,  0, 0, 0, S_FLUSH, O_STALL);
      step("restall_done", 0, 11, 1, 0,  0, 0,  0, 0, 0, S_STALL, O_NONE);
      step("jump_no_iss",  0, 0,  0, 0,  0, 12, 1, 1, 0, S_RUN,   O_JUMP);
      step("r12_free",     0, 12, 1, 0,  0, 0,  0, 0, 0, S_FLUSH, O_NONE);
      step("issue_r13",    0, 0,  0, 0,  0, 13, 1, 0, 0, S_RUN,   O_NONE);
      step("r13_stall",    0, 13, 1, 0,  0, 0,  0, 0, 0, S_RUN,   O_STALL);

      // Reset pulse between edges while in STALL with r13 still pending.
      @(posedge clk);
      #1;
      check_now("pre_rst_stall", {S_STALL, O_STALL});
      #1 rst = 1'b1;
      xm_branch = 1'b1;
      #1;
      check_now("async_rst_out", {S_INIT, O_STALL});
      nz = 0;
      for (int i = 0; i < 32; i++) if (dut.u_sb.r_sb[i] != '0) nz++;
      n_checks++;
      if (nz != 0) begin
         n_err++;
         $display("FAIL sb_clear: %0d nonzero entries, expected 0", nz);
      end
      #1 rst = 1'b0;
      xm_branch = 1'b0;
      step("rst_init_c1",  0, 13, 1, 0,  0, 0,  0, 0, 0, S_INIT,  O_STALL);
      step("rst_run",      0, 13, 1, 13, 1, 0,  0, 0, 0, S_RUN,   O_NONE);

      for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
      if (q.size() != 0) begin
         n_checks++;
         n_err++;
         $display("FAIL drain: %0d pending, expected 0", q.size());
      end
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
